alu_share_arbiter: RTL and testbench

- Shares the single 8-bit ALU (FORWARD/ADD/AND/OR, SELECT 000–011) between two requesters, for example the CPU control path and the cache/memory controller.
- Performs round-robin arbitration and latches the winner's operands onto the ALU inputs.
- Holds those inputs for a programmable settle time to cover the ALU's combinational delays, then captures RESULT/ZERO and returns them with a one-cycle DONE pulse.
- Rejects unsupported opcodes without touching the ALU.

---
 rtl/alu_share_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external 8-bit ALU (FORWARD/ADD/AND/OR) between two requesters.
// Round-robin arbitration picks a winner in IDLE. For a legal opcode its
// operands are latched onto the ALU inputs and held for WAIT_CYCLES edges
// before RESULT/ZERO are captured. The result is returned with a one-cycle
// DONEx pulse. Opcodes 1xx never touch the ALU and complete at once with ERR.
//
// Parameters
//   WAIT_CYCLES    edges the ALU inputs are held before sampling (1..7)
//
// Ports
//   CLK, RESET                 clock (rising edge), async active-low reset
//   REQx/OPx/Ax/Bx             requester x request, select code, operands
//   GNTx                       requester x owns the ALU (EXEC and DONE)
//   DONEx                      one-cycle completion pulse for requester x
//   RESULT/ZERO/ERR            captured result, valid while DONEx is high
//   BUSY                       arbiter not idle
//   ALU_DATA1/2, ALU_SELECT    registered drive to the shared ALU
//   ALU_RESULT, ALU_ZERO       ALU outputs
//
// Optional build macro ALU_ARB_STATS_EN adds the saturating per-requester
// completion counters GRANT_CNT0/GRANT_CNT1.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic [2:0] OP0,
   input  logic [7:0] A0,
   input  logic [7:0] B0,
   input  logic       REQ1,
   input  logic [2:0] OP1,
   input  logic [7:0] A1,
   input  logic [7:0] B1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       DONE0,
   output logic       DONE1,
   output logic [7:0] RESULT,
   output logic       ZERO,
   output logic       ERR,
   output logic       BUSY,
   output logic [7:0] ALU_DATA1,
   output logic [7:0] ALU_DATA2,
   output logic [2:0] ALU_SELECT,
   input  logic [7:0] ALU_RESULT,
   input  logic       ALU_ZERO
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0] GRANT_CNT0,
   output logic [7:0] GRANT_CNT1
`endif
);

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;     // 0: requester 0 owns the ALU, 1: requester 1
   logic       rr_q, rr_d;           // requester preferred when both request
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] result_q, result_d;
   logic       zero_q, zero_d;
   logic       err_q, err_d;
   logic [7:0] data1_q, data1_d;
   logic [7:0] data2_q, data2_d;
   logic [2:0] select_q, select_d;

   logic       req_any;
   logic       win1;
   logic [2:0] win_op;
   logic [7:0] win_a;
   logic [7:0] win_b;

   // Configuration sanity check, evaluated in simulation only.
   always_ff @(posedge CLK) begin
      assert (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 7);
   end

   // Arbitration: a lone requester always wins; on contention rr_q decides.
   always_comb begin
      req_any = REQ0 | REQ1;
      win1    = REQ1 & (~REQ0 | rr_q);
      win_op  = win1 ? OP1 : OP0;
      win_a   = win1 ? A1  : A0;
      win_b   = win1 ? B1  : B0;
   end

   // State register and datapath registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         rr_q     <= 1'b0;
         cnt_q    <= 3'd0;
         result_q <= 8'd0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         data1_q  <= 8'd0;
         data2_q  <= 8'd0;
         select_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         select_q <= select_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_any) state_d = win_op[2] ? ST_DONE : ST_EXEC;
         ST_EXEC: if (cnt_q == 3'd1) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      owner_d  = owner_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      data1_d  = data1_q;
      data2_d  = data2_q;
      select_d = select_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               owner_d = win1;
               if (win_op[2]) begin
                  // Unsupported opcode: ALU inputs keep their previous drive.
                  result_d = 8'd0;
                  zero_d   = 1'b0;
                  err_d    = 1'b1;
               end else begin
                  data1_d  = win_a;
                  data2_d  = win_b;
                  select_d = win_op;
                  cnt_d    = WAIT_INIT;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               result_d = ALU_RESULT;
               zero_d   = ALU_ZERO;
               err_d    = 1'b0;
            end
         end
         ST_DONE: rr_d = ~owner_q;
         default: ;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      BUSY  = (state_q != ST_IDLE);
      GNT0  = BUSY & ~owner_q;
      GNT1  = BUSY &  owner_q;
      DONE0 = (state_q == ST_DONE) & ~owner_q;
      DONE1 = (state_q == ST_DONE) &  owner_q;
   end

   assign RESULT     = result_q;
   assign ZERO       = zero_q;
   assign ERR        = err_q;
   assign ALU_DATA1  = data1_q;
   assign ALU_DATA2  = data2_q;
   assign ALU_SELECT = select_q;

`ifdef ALU_ARB_STATS_EN
   logic [7:0] gcnt0_q, gcnt0_d;
   logic [7:0] gcnt1_q, gcnt1_d;
   logic       enter_done;

   // Count completions (including ERR ones) on entry to DONE, saturating.
   always_comb begin
      gcnt0_d    = gcnt0_q;
      gcnt1_d    = gcnt1_q;
      enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
      if (enter_done) begin
         if (!owner_d && gcnt0_q != 8'hFF) gcnt0_d = gcnt0_q + 8'd1;
         if ( owner_d && gcnt1_q != 8'hFF) gcnt1_d = gcnt1_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         gcnt0_q <= 8'd0;
         gcnt1_q <= 8'd0;
      end else begin
         gcnt0_q <= gcnt0_d;
         gcnt1_q <= gcnt1_d;
      end
   end

   assign GRANT_CNT0 = gcnt0_q;
   assign GRANT_CNT1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter with a behavioural model of the shared
// ALU (000 FORWARD DATA2, 001 ADD, 010 AND, 011 OR). Inputs are driven on the
// falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

   localparam int W = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       REQ0 = 1'b0, REQ1 = 1'b0;
   logic [2:0] OP0 = 3'd0, OP1 = 3'd0;
   logic [7:0] A0 = 8'd0, B0 = 8'd0, A1 = 8'd0, B1 = 8'd0;
   logic       GNT0, GNT1, DONE0, DONE1, ZERO, ERR, BUSY;
   logic [7:0] RESULT, ALU_DATA1, ALU_DATA2;
   logic [2:0] ALU_SELECT;
   logic [7:0] ALU_RESULT;
   logic       ALU_ZERO;
`ifdef ALU_ARB_STATS_EN
   logic [7:0] GRANT_CNT0, GRANT_CNT1;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 CLK = ~CLK;

   alu_share_arbiter #(.WAIT_CYCLES(W)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0),
      .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
      .RESULT(RESULT), .ZERO(ZERO), .ERR(ERR), .BUSY(BUSY),
      .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
      .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO)
`ifdef ALU_ARB_STATS_EN
      , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1)
`endif
   );

   // Shared ALU model
   always_comb begin
      case (ALU_SELECT)
         3'd0:    ALU_RESULT = ALU_DATA2;
         3'd1:    ALU_RESULT = ALU_DATA1 + ALU_DATA2;
         3'd2:    ALU_RESULT = ALU_DATA1 & ALU_DATA2;
         3'd3:    ALU_RESULT = ALU_DATA1 | ALU_DATA2;
         default: ALU_RESULT = 8'd0;
      endcase
      ALU_ZERO = (ALU_RESULT == 8'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for a DONE pulse, counting rising edges; bounded.
   task automatic wait_done(output int who, output int edges);
      who = -1;
      edges = 0;
      while (who < 0 && edges < 20) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         if (DONE0 || DONE1) who = DONE1 ? 1 : 0;
      end
      if (who < 0) chk("done_timeout", {31'd0, DONE0 | DONE1}, 32'd1);
      chk("done_onehot", {31'd0, DONE0 & DONE1}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"},    {30'd0, GNT1, GNT0}, 32'd0);
      chk({tag, "_done"},   {30'd0, DONE1, DONE0}, 32'd0);
      chk({tag, "_busy"},   {31'd0, BUSY}, 32'd0);
      chk({tag, "_result"}, {24'd0, RESULT}, 32'd0);
      chk({tag, "_zero"},   {31'd0, ZERO}, 32'd0);
      chk({tag, "_err"},    {31'd0, ERR}, 32'd0);
      chk({tag, "_alu"},    {13'd0, ALU_SELECT, ALU_DATA2, ALU_DATA1}, 32'd0);
   endtask

   // Check one completion, then drop both requests and check return to IDLE.
   task automatic finish_op(input string tag, input int who, input int exp_who,
                            input logic [7:0] exp_res, input logic exp_zero,
                            input logic exp_err, input int edges, input int exp_edges);
      $display("txn %-10s: winner=%0d result=%02h zero=%0b err=%0b edges=%0d",
               tag, who, RESULT, ZERO, ERR, edges);
      chk({tag, "_who"},    who, exp_who);
      chk({tag, "_lat"},    edges, exp_edges);
      chk({tag, "_result"}, {24'd0, RESULT}, {24'd0, exp_res});
      chk({tag, "_zero"},   {31'd0, ZERO}, {31'd0, exp_zero});
      chk({tag, "_err"},    {31'd0, ERR}, {31'd0, exp_err});
      chk({tag, "_gnt"},    {30'd0, GNT1, GNT0}, (exp_who == 1) ? 32'd2 : 32'd1);
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk({tag, "_idle"}, {29'd0, BUSY, GNT1 | GNT0, DONE1 | DONE0}, 32'd0);
   endtask

   task automatic run_op(input string tag, input int who, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_zero,
                         input logic exp_err, input int exp_edges);
      int w, e;
      if (who == 0) begin
         REQ0 = 1'b1; OP0 = op; A0 = a; B0 = b;
      end else begin
         REQ1 = 1'b1; OP1 = op; A1 = a; B1 = b;
      end
      wait_done(w, e);
      finish_op(tag, w, who, exp_res, exp_zero, exp_err, e, exp_edges);
   endtask

   int               w, e;
   logic [7:0]       rr_res [4] = '{8'h11, 8'h03, 8'h11, 8'h03};
   int               pulses;
   int               budget;

   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      check_reset_outputs("reset");
      RESET = 1'b1;
      @(negedge CLK);

      // ADD 05+03 by requester 0
      run_op("add0", 0, 3'b001, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, W + 1);
      chk("add0_alu", {13'd0, ALU_SELECT, ALU_DATA2, ALU_DATA1}, {13'd0, 3'b001, 8'h03, 8'h05});

      // AND F0&0F by requester 1 -> zero
      run_op("and1", 1, 3'b010, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, W + 1);

      // Both held high: grants alternate 0,1,0,1
      REQ0 = 1'b1; OP0 = 3'b000; A0 = 8'h00; B0 = 8'h11;
      REQ1 = 1'b1; OP1 = 3'b011; A1 = 8'h01; B1 = 8'h02;
      for (int i = 0; i < 4; i++) begin
         wait_done(w, e);
         $display("txn rr%0d       : winner=%0d result=%02h edges=%0d", i, w, RESULT, e);
         chk($sformatf("rr%0d_who", i), w, i % 2);
         chk($sformatf("rr%0d_result", i), {24'd0, RESULT}, {24'd0, rr_res[i]});
         // first grant starts from IDLE; later ones include the DONE->IDLE edge
         chk($sformatf("rr%0d_lat", i), e, (i == 0) ? W + 1 : W + 2);
      end
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      @(posedge CLK);
      @(negedge CLK);

      // Illegal opcode: immediate completion, ALU drive untouched
      run_op("illegal0", 0, 3'b101, 8'hAA, 8'hBB, 8'h00, 1'b0, 1'b1, 1);
      chk("illegal_alu", {13'd0, ALU_SELECT, ALU_DATA2, ALU_DATA1}, {13'd0, 3'b011, 8'h02, 8'h01});

      // rr pointer now prefers requester 1
      REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'h02; B0 = 8'h02;
      REQ1 = 1'b1; OP1 = 3'b011; A1 = 8'h01; B1 = 8'h02;
      wait_done(w, e);
      finish_op("rr_after", w, 1, 8'h03, 1'b0, 1'b0, e, W + 1);

      // Make rr point at requester 1 again, then abort an ADD by reset
      run_op("and0", 0, 3'b010, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1'b0, W + 1);
      REQ1 = 1'b1; OP1 = 3'b001; A1 = 8'h10; B1 = 8'h20;
      @(posedge CLK);
      @(negedge CLK);
      chk("abort_exec", {29'd0, BUSY, GNT1, GNT0}, 32'b110);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check_reset_outputs("abort");
      $display("txn abort     : reset asserted during EXEC of requester 1 ADD");
      REQ1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("abort_nodone", {30'd0, DONE1, DONE0}, 32'd0);
      end
      RESET = 1'b1;
      @(negedge CLK);

      // After reset requester 0 is preferred again
      REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'h07; B0 = 8'h08;
      REQ1 = 1'b1; OP1 = 3'b000; A1 = 8'h00; B1 = 8'h55;
      wait_done(w, e);
      finish_op("post_rst", w, 0, 8'h0F, 1'b0, 1'b0, e, W + 1);

`ifdef ALU_ARB_STATS_EN
      chk("stats_start0", {24'd0, GRANT_CNT0}, 32'd1);
      chk("stats_start1", {24'd0, GRANT_CNT1}, 32'd0);
      REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'h01; B0 = 8'h01;
      pulses = 0;
      budget = 0;
      while (pulses < 300 && budget < 3000) begin
         @(negedge CLK);
         budget++;
         if (DONE0) begin
            pulses++;
            if (pulses == 100) chk("stats_mid0", {24'd0, GRANT_CNT0}, 32'd101);
         end
      end
      REQ0 = 1'b0;
      if (pulses < 300) chk("stats_timeout", pulses, 300);
      $display("txn stats     : %0d back-to-back ops, cnt0=%0d cnt1=%0d", pulses, GRANT_CNT0, GRANT_CNT1);
      chk("stats_sat0", {24'd0, GRANT_CNT0}, 32'd255);
      chk("stats_cnt1", {24'd0, GRANT_CNT1}, 32'd0);
      repeat (2) @(negedge CLK);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
